// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: picks BIOS ROM or relocated process memory per fetch,
// bounds-checks and times out memory reads, and hands words to the core.
module inst_fetch_unit #(
    parameter int unsigned ADDR_W     = 32,
    parameter logic [15:0] TIMEOUT    = 16'd1024,
    parameter logic [31:0] FAULT_INST = 32'h01000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       pc,
    input  logic [0:31]       bios_instruction,
    input  logic              controll,
    input  logic [1:0]        bios_state,
    input  logic [31:0]       proc_base,
    input  logic [31:0]       proc_limit,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [0:31]       instruction,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic              done_inst,
    output logic              fetch_fault
);

    typedef enum logic [1:0] {IDLE, SEL, MWAIT, VALID} state_t;

    state_t      state;
    logic        src;
    logic        was_proc;
    logic [31:0] base_reg;
    logic [15:0] timer;
    logic [31:0] reloc;

    assign reloc = base_reg + pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            src         <= 1'b0;
            was_proc    <= 1'b0;
            base_reg    <= '0;
            timer       <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            instruction <= '0;
            inst_valid  <= 1'b0;
            done_inst   <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            done_inst <= 1'b0;
            was_proc  <= (bios_state == 2'd2);
            // base only moves on entry to PROCESSEXEC; an in-flight address is untouched
            if (bios_state == 2'd2 && !was_proc)
                base_reg <= proc_base;
            unique case (state)
                IDLE: begin
                    if (bios_state != 2'd0)
                        state <= SEL;
                end
                SEL: begin
                    src <= controll;
                    if (bios_state == 2'd0) begin
                        state <= IDLE;
                    end else if (controll) begin
                        instruction <= bios_instruction;
                        inst_valid  <= 1'b1;
                        state       <= VALID;
                    end else if (pc >= proc_limit) begin
                        instruction <= FAULT_INST;
                        fetch_fault <= 1'b1;
                        inst_valid  <= 1'b1;
                        state       <= VALID;
                    end else begin
                        mem_addr <= ADDR_W'(reloc);
                        mem_req  <= 1'b1;
                        timer    <= '0;
                        state    <= MWAIT;
                    end
                end
                MWAIT: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (controll != src) begin
                            state <= SEL;
                        end else begin
                            instruction <= mem_rdata;
                            inst_valid  <= 1'b1;
                            state       <= VALID;
                        end
                    end else if (timer == TIMEOUT - 16'd1) begin
                        mem_req     <= 1'b0;
                        instruction <= FAULT_INST;
                        fetch_fault <= 1'b1;
                        inst_valid  <= 1'b1;
                        state       <= VALID;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                VALID: begin
                    if (inst_ready) begin
                        inst_valid  <= 1'b0;
                        fetch_fault <= 1'b0;
                        done_inst   <= 1'b1;
                        state       <= (bios_state == 2'd0) ? IDLE : SEL;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
